// File: rtl/ddr2_arb_pkg.sv
// Shared constants for the DDR2 local-port arbiter: requester address layout and requester ids.
// Address packing is {row, bank, col}, column in the least significant bits.
package ddr2_arb_pkg;
    localparam int ARB_DATA_W         = 256;
    localparam int ARB_ADDR_W         = 26;
    localparam int ARB_ROW_W          = 14;
    localparam int ARB_BANK_W         = 3;
    localparam int ARB_COL_W          = 9;
    localparam int ARB_MAX_HOLD       = 8;
    localparam int ARB_RD_OUTSTANDING = 16;

    localparam int COL_LSB  = 0;
    localparam int BANK_LSB = ARB_COL_W;
    localparam int ROW_LSB  = ARB_COL_W + ARB_BANK_W;

    localparam logic REQ_ACQ  = 1'b0;
    localparam logic REQ_HOST = 1'b1;
endpackage

// File: rtl/ddr2_local_port_arbiter_if.sv
// Requester-side and controller-side signals of the local-port arbiter.
// slave = arbiter's view; master = the surrounding requesters and controller wrapper.
interface ddr2_local_port_arbiter_if
    import ddr2_arb_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int ROW_W  = ARB_ROW_W,
    parameter int BANK_W = ARB_BANK_W,
    parameter int COL_W  = ARB_COL_W
);
    logic [1:0]          rq_read;
    logic [1:0]          rq_write;
    logic [ADDR_W-1:0]   rq_addr0;
    logic [ADDR_W-1:0]   rq_addr1;
    logic [DATA_W-1:0]   rq_wdata0;
    logic [DATA_W-1:0]   rq_wdata1;
    logic [DATA_W/8-1:0] rq_be0;
    logic [DATA_W/8-1:0] rq_be1;
    logic [1:0]          rq_waitreq;
    logic [DATA_W-1:0]   rq_rdata;
    logic [1:0]          rq_rdvalid;

    logic                local_ready;
    logic                local_init_done;
    logic [DATA_W-1:0]   local_rdata;
    logic                local_rdata_valid;
    logic                local_read_req;
    logic                local_write_req;
    logic                local_burstbegin;
    logic                local_size;
    logic [ROW_W-1:0]    local_row_addr;
    logic [BANK_W-1:0]   local_bank_addr;
    logic [COL_W-1:0]    local_col_addr;
    logic                local_cs_addr;
    logic [DATA_W-1:0]   local_wdata;
    logic [DATA_W/8-1:0] local_be;
    logic                err_orphan;

    modport slave (
        input  rq_read, rq_write, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1, rq_be0, rq_be1,
        input  local_ready, local_init_done, local_rdata, local_rdata_valid,
        output rq_waitreq, rq_rdata, rq_rdvalid,
        output local_read_req, local_write_req, local_burstbegin, local_size,
        output local_row_addr, local_bank_addr, local_col_addr, local_cs_addr,
        output local_wdata, local_be, err_orphan
    );

    modport master (
        output rq_read, rq_write, rq_addr0, rq_addr1, rq_wdata0, rq_wdata1, rq_be0, rq_be1,
        output local_ready, local_init_done, local_rdata, local_rdata_valid,
        input  rq_waitreq, rq_rdata, rq_rdvalid,
        input  local_read_req, local_write_req, local_burstbegin, local_size,
        input  local_row_addr, local_bank_addr, local_col_addr, local_cs_addr,
        input  local_wdata, local_be, err_orphan
    );
endinterface

// File: rtl/ddr2_arb_owner_fifo.sv
// Read-owner FIFO: 1-bit requester ids in issue order, with occupancy count.
// Latency: head visible the cycle after push; pop takes effect at the next edge.
// Backpressure: push ignored when full unless a pop frees the slot in the same cycle.
module ddr2_arb_owner_fifo #(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_dat,
    input  logic             pop,
    output logic             pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/ddr2_local_port_arbiter.sv
// Two-requester round-robin arbiter for the DDR2 local port with bounded grant hold and in-order read return.
// Latency: command path and read-return routing are combinational (zero cycles).
// Backpressure: rq_waitreq high unless granted and local_ready; reads throttled at RD_OUTSTANDING in flight.
module ddr2_local_port_arbiter
    import ddr2_arb_pkg::*;
#(
    parameter int DATA_W         = ARB_DATA_W,
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int ROW_W          = ARB_ROW_W,
    parameter int BANK_W         = ARB_BANK_W,
    parameter int COL_W          = ARB_COL_W,
    parameter int MAX_HOLD       = ARB_MAX_HOLD,
    parameter int RD_OUTSTANDING = ARB_RD_OUTSTANDING
) (
    input logic                       clk,
    input logic                       reset,
    ddr2_local_port_arbiter_if.slave  bus
);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int CNT_W  = $clog2(RD_OUTSTANDING + 1);

    logic              owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              err_orphan_q, err_orphan_d;

    logic [1:0]        elig_wr, elig_rd, elig;
    logic              rd_room, other_id;
    logic              gnt_vld, gnt_id, gnt_is_wr, accept;
    logic [ADDR_W-1:0] gnt_addr;

    logic              fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  outstanding;

    // Write wins over a simultaneous read on the same requester; the read simply stays waited.
    always_comb begin
        rd_room  = (outstanding < CNT_W'(RD_OUTSTANDING));
        elig_wr  = bus.rq_write & {2{bus.local_init_done && !reset}};
        elig_rd  = bus.rq_read & ~bus.rq_write & {2{bus.local_init_done && rd_room && !reset}};
        elig     = elig_wr | elig_rd;
        other_id = ~owner_q;
        gnt_vld  = 1'b0;
        gnt_id   = owner_q;
        if (elig[owner_q] && ((hold_q < HOLD_W'(MAX_HOLD)) || !elig[other_id])) begin
            gnt_vld = 1'b1;
            gnt_id  = owner_q;
        end else if (elig[other_id]) begin
            gnt_vld = 1'b1;
            gnt_id  = other_id;
        end
        gnt_is_wr = elig_wr[gnt_id];
        accept    = gnt_vld && bus.local_ready;
        gnt_addr  = gnt_id ? bus.rq_addr1 : bus.rq_addr0;
    end

    always_comb begin
        bus.local_write_req  = gnt_vld && gnt_is_wr;
        bus.local_read_req   = gnt_vld && !gnt_is_wr;
        bus.local_burstbegin = gnt_vld;
        bus.local_size       = 1'b1;
        bus.local_cs_addr    = 1'b0;
        bus.local_row_addr   = gnt_addr[ROW_LSB +: ROW_W];
        bus.local_bank_addr  = gnt_addr[BANK_LSB +: BANK_W];
        bus.local_col_addr   = gnt_addr[COL_LSB +: COL_W];
        bus.local_wdata      = gnt_id ? bus.rq_wdata1 : bus.rq_wdata0;
        bus.local_be         = gnt_id ? bus.rq_be1 : bus.rq_be0;
        bus.rq_waitreq       = 2'b11;
        if (accept) begin
            bus.rq_waitreq[gnt_id] = 1'b0;
        end
    end

    // A beat arriving with nothing owed is dropped and flagged rather than misrouted.
    always_comb begin
        fifo_push                = accept && !gnt_is_wr && !fifo_full;
        fifo_pop                 = bus.local_rdata_valid && !fifo_empty && !reset;
        bus.rq_rdata             = bus.local_rdata;
        bus.rq_rdvalid           = 2'b00;
        bus.rq_rdvalid[REQ_ACQ]  = fifo_pop && (fifo_head == REQ_ACQ);
        bus.rq_rdvalid[REQ_HOST] = fifo_pop && (fifo_head == REQ_HOST);
        bus.err_orphan           = err_orphan_q;
        err_orphan_d             = err_orphan_q || (bus.local_rdata_valid && fifo_empty && !reset);
    end

    always_comb begin
        owner_d = owner_q;
        hold_d  = hold_q;
        if (accept) begin
            if (gnt_id == owner_q) begin
                if (hold_q < HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end else begin
                owner_d = gnt_id;
                hold_d  = HOLD_W'(1);
            end
        end else if (!gnt_vld) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= REQ_ACQ;
            hold_q       <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            hold_q       <= hold_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    ddr2_arb_owner_fifo #(
        .DEPTH (RD_OUTSTANDING)
    ) u_owner_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (gnt_id),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );
endmodule

// File: tb/tb_ddr2_local_port_arbiter.sv
// Directed and randomized bench for the DDR2 local-port arbiter against a behavioural arbitration/read-order model.
module tb_ddr2_local_port_arbiter;
    localparam int MAX_HOLD = 8;
    localparam int RD_OUT   = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   m_owner, m_hold;
    int   q[$];
    bit   m_orphan;
    bit   m_gv, m_wr;
    int   m_gid;
    int   obs_acc;

    ddr2_local_port_arbiter_if bus ();

    ddr2_local_port_arbiter dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic new_payload(input int i);
        if (i == 0) begin
            bus.rq_addr0 = 26'($urandom()); bus.rq_wdata0 = rnd256(); bus.rq_be0 = $urandom();
        end else begin
            bus.rq_addr1 = 26'($urandom()); bus.rq_wdata1 = rnd256(); bus.rq_be1 = $urandom();
        end
    endtask

    // Mid-cycle: derive who should be served from the rules, then compare every DUT output.
    task automatic settle();
        bit [1:0]     el;
        logic [1:0]   ew, erv;
        logic [25:0]  a;
        #4;
        for (int i = 0; i < 2; i++)
            el[i] = !rst && bus.local_init_done &&
                    (bus.rq_write[i] || (bus.rq_read[i] && q.size() < RD_OUT));
        m_gv  = 0;
        m_gid = m_owner;
        if (el[m_owner] && (m_hold < MAX_HOLD || !el[1-m_owner])) m_gv = 1;
        else if (el[1-m_owner]) begin m_gv = 1; m_gid = 1 - m_owner; end
        m_wr = bus.rq_write[m_gid];
        ew = 2'b11;
        if (m_gv && bus.local_ready) ew[m_gid] = 1'b0;
        erv = 2'b00;
        if (!rst && bus.local_rdata_valid && q.size() > 0) erv[q[0]] = 1'b1;
        chk("waitreq", bus.rq_waitreq, ew);
        chk("write_req", bus.local_write_req, m_gv && m_wr);
        chk("read_req", bus.local_read_req, m_gv && !m_wr);
        chk("burstbegin", bus.local_burstbegin, m_gv);
        chk("rdvalid", bus.rq_rdvalid, erv);
        chk("rdata", bus.rq_rdata, bus.local_rdata);
        chk("size", bus.local_size, 1'b1);
        chk("cs", bus.local_cs_addr, 1'b0);
        if (m_gv) begin
            a = m_gid ? bus.rq_addr1 : bus.rq_addr0;
            chk("row", bus.local_row_addr, a / 4096);
            chk("bank", bus.local_bank_addr, (a / 512) % 8);
            chk("col", bus.local_col_addr, a % 512);
            chk("wdata", bus.local_wdata, m_gid ? bus.rq_wdata1 : bus.rq_wdata0);
            chk("be", bus.local_be, m_gid ? bus.rq_be1 : bus.rq_be0);
        end
        if (!rst) chk("err_orphan", bus.err_orphan, m_orphan);
        obs_acc = !bus.rq_waitreq[0] ? 0 : (!bus.rq_waitreq[1] ? 1 : -1);
    endtask

    task automatic tick();
        bit acc;
        acc = m_gv && bus.local_ready;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_hold = 0; q.delete(); m_orphan = 0;
        end else begin
            if (bus.local_rdata_valid) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_orphan = 1;
            end
            if (acc) begin
                if (!m_wr) q.push_back(m_gid);
                if (m_gid == m_owner) m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
                else begin m_owner = m_gid; m_hold = 1; end
            end else if (!m_gv) begin
                m_hold = 0;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    initial begin
        int          seq[4];
        logic [1:0]  exp_rv[4];
        logic [255:0] saved_wdata;
        logic [31:0] saved_be;
        int          acc_cnt;
        bit [1:0]    pending;

        seq    = '{0, 1, 1, 0};
        exp_rv = '{2'b01, 2'b10, 2'b10, 2'b01};
        m_owner = 0; m_hold = 0; m_orphan = 0;

        rst = 1'b1;
        bus.rq_read = 2'b00; bus.rq_write = 2'b00;
        new_payload(0); new_payload(1);
        bus.local_ready = 1'b1; bus.local_init_done = 1'b0;
        bus.local_rdata = rnd256(); bus.local_rdata_valid = 1'b0;
        step(); step();
        rst = 1'b0;

        // Calibration not done: nothing may reach the controller.
        bus.rq_write = 2'b11;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("init_gate_wait", bus.rq_waitreq, 2'b11);
            chk("init_gate_wr", bus.local_write_req, 1'b0);
            tick();
        end

        bus.local_init_done = 1'b1;
        for (int k = 0; k < 32; k++) begin
            settle();
            chk("fair_seq", obs_acc, (k / 8) % 2);
            tick();
            if (obs_acc >= 0) new_payload(obs_acc);
        end

        bus.rq_write = 2'b01;
        bus.rq_addr0 = 26'h3FF_FFFF;
        settle();
        chk("dec_row", bus.local_row_addr, 14'h3FFF);
        chk("dec_bank", bus.local_bank_addr, 3'h7);
        chk("dec_col", bus.local_col_addr, 9'h1FF);
        tick();
        new_payload(0);

        bus.rq_write = 2'b10;
        bus.local_ready = 1'b0;
        saved_wdata = bus.rq_wdata1;
        saved_be    = bus.rq_be1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_wait1", bus.rq_waitreq[1], 1'b1);
            chk("stall_wdata", bus.local_wdata, saved_wdata);
            chk("stall_be", bus.local_be, saved_be);
            tick();
        end
        bus.local_ready = 1'b1;
        settle();
        chk("stall_release", obs_acc, 1);
        tick();
        new_payload(1);
        // Stalled cycles must not have used up requester 1's quota: 7 more beats, then a switch.
        bus.rq_write = 2'b11;
        for (int j = 0; j < 8; j++) begin
            settle();
            chk("post_stall_hold", obs_acc, (j < 7) ? 1 : 0);
            tick();
            if (obs_acc >= 0) new_payload(obs_acc);
        end
        bus.rq_write = 2'b00;

        for (int c = 0; c < 7; c++) begin
            bus.rq_read = (c < 4) ? (seq[c] ? 2'b10 : 2'b01) : 2'b00;
            bus.local_rdata_valid = (c >= 3);
            bus.local_rdata = rnd256();
            settle();
            if (c >= 3) chk("rd_order", bus.rq_rdvalid, exp_rv[c-3]);
            tick();
        end

        bus.rq_read = 2'b10;
        bus.local_rdata_valid = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (obs_acc == 1) acc_cnt++;
            tick();
        end
        chk("thr_accepted", acc_cnt, 16);
        settle();
        chk("thr_full_wait", bus.rq_waitreq[1], 1'b1);
        tick();
        bus.local_rdata_valid = 1'b1;
        settle();
        chk("thr_pop_nopush", bus.rq_waitreq[1], 1'b1);
        chk("thr_pop_rdv", bus.rq_rdvalid, 2'b10);
        tick();
        settle();
        chk("thr_pushpop_acc", bus.rq_waitreq[1], 1'b0);
        chk("thr_pushpop_rdv", bus.rq_rdvalid, 2'b10);
        tick();
        bus.local_rdata_valid = 1'b0;
        settle();
        chk("thr_refill", bus.rq_waitreq[1], 1'b0);
        tick();
        settle();
        chk("thr_full_again", bus.rq_waitreq[1], 1'b1);
        tick();

        bus.rq_read = 2'b00;
        bus.local_rdata_valid = 1'b1;
        for (int i = 0; i < 13; i++) step();
        bus.local_rdata_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.local_rdata_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("orphan_rdv", bus.rq_rdvalid, 2'b00);
            tick();
        end
        bus.local_rdata_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("orphan_sticky", bus.err_orphan, 1'b1);
            tick();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("orphan_cleared", bus.err_orphan, 1'b0);
        tick();

        // Randomized traffic; a waited request is held stable until accepted.
        pending = 2'b00;
        for (int n = 0; n < 400; n++) begin
            bus.local_ready       = ($urandom_range(0, 3) != 0);
            bus.local_init_done   = ($urandom_range(0, 15) != 0);
            bus.local_rdata_valid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
            bus.local_rdata       = rnd256();
            settle();
            tick();
            if (obs_acc >= 0) begin
                if (m_wr) bus.rq_write[obs_acc] = 1'b0;
                else      bus.rq_read[obs_acc]  = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                pending[i] = bus.rq_read[i] || bus.rq_write[i];
                if (!pending[i]) begin
                    int r;
                    r = $urandom_range(0, 3);
                    bus.rq_read[i]  = (r == 1) || (r == 3);
                    bus.rq_write[i] = (r >= 2);
                    new_payload(i);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
